// File: rtl/hazard_unit.sv
// Load-use / flag stall and branch flush control for the in-order pipeline.
// Define HAZARD_STATS_EN to add the stall_cnt / flush_cnt statistics ports.
module hazard_unit #(
  parameter int unsigned BRANCH_PENALTY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_uses_rm,
  input  logic       id_mem_read,
  input  logic       id_reg_write,
  input  logic [4:0] id_rd,
  input  logic       id_set_flags,
  input  logic       id_flag_branch,
  input  logic       br_taken,
  output logic       bubble_ctrl,
  output logic       pc_write_en,
  output logic       ifid_write_en,
  output logic       ifid_flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] PEN_M1 = 3'(BRANCH_PENALTY - 1);
  localparam logic [4:0] XZR = 5'd31;

  state_t     state, state_n;
  logic [2:0] flush_left, left_n;

  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_reg_write;
  logic       ex_set_flags;

  logic       load_use;
  logic       flag_haz;
  logic       stall_now;

  assign load_use = id_valid & ex_mem_read & ex_reg_write
                  & (ex_rd != XZR)
                  & ((ex_rd == id_rn)
                     | (id_uses_rm & (ex_rd == id_rm)));

  assign flag_haz = id_valid & id_flag_branch & ex_set_flags;

  // EX shadow: what ID issues this cycle, or nothing if bubbled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rd        <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_set_flags <= 1'b0;
    end else if (bubble_ctrl || !id_valid) begin
      ex_rd        <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_set_flags <= 1'b0;
    end else begin
      ex_rd        <= id_rd;
      ex_mem_read  <= id_mem_read;
      ex_reg_write <= id_reg_write;
      ex_set_flags <= id_set_flags;
    end
  end

  // FSM state and flush down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      flush_left <= '0;
    end else begin
      state      <= state_n;
      flush_left <= left_n;
    end
  end

  // Next state: a taken branch always (re)starts the flush window
  always_comb begin
    state_n = state;
    left_n  = flush_left;
    if (br_taken) begin
      if (BRANCH_PENALTY == 1) begin
        state_n = RUN;
        left_n  = '0;
      end else begin
        state_n = FLUSH;
        left_n  = PEN_M1;
      end
    end else if (state == FLUSH) begin
      if (flush_left <= 3'd1) begin
        state_n = RUN;
        left_n  = '0;
      end else begin
        left_n  = flush_left - 3'd1;
      end
    end
  end

  // Outputs: flush beats stall; reset holds the pipeline free-running
  always_comb begin
    bubble_ctrl   = 1'b0;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    stall_now     = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        (br_taken || state == FLUSH): begin
          bubble_ctrl = 1'b1;
          ifid_flush  = 1'b1;
        end
        (!br_taken && state == RUN
         && (load_use || flag_haz)): begin
          bubble_ctrl   = 1'b1;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          stall_now     = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_now && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
